skinny_inv_sbox8_dom1_dep_hs: RTL

First-order DOM-dep masked inverse SKINNY 8-bit S-box with a valid/ready handshake, for the decryption datapath of the masked SKINNY-128-384+ core. It is the mirror of the forward masked sbox8. It accepts a two-share byte plus 16 bits of fresh randomness. It holds those operands internally stable for the whole computation and returns the two-share inverse S-box output. Inverting four NOR-XOR layers needs eight masked NOR gadgets at depth 4.

---
 rtl/skinny_inv_sbox8_dom1_dep_hs.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/skinny_inv_sbox8_dom1_dep_hs.sv
// First-order DOM-dep masked inverse SKINNY 8-bit S-box with valid/ready.
// Eight masked NOR gadgets in four layers read only the captured operands.

module skinny_inv_nor_gadget (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1,
    input  logic       p0,
    input  logic       q1,
    input  logic       q0,
    input  logic       z1,
    input  logic       z0,
    input  logic [1:0] r,
    output logic       o1,
    output logic       o0
);
    logic a1, a0, b1, b0;
    logic g1_d, g1_q, g0_d, g0_q;
    logic t1_d, t1_q, t0_d, t0_q;

    // nor(p,q) = ~p & ~q; inverting one share negates the shared value
    always_comb begin
        a1 = ~p1;
        a0 = p0;
        b1 = ~q1;
        b0 = q0;
        g1_d = b1 ^ r[0];
        g0_d = b0 ^ r[0];
        t1_d = (a1 & r[0]) ^ r[1] ^ z1;
        t0_d = (a0 & r[0]) ^ r[1] ^ z0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g1_q <= 1'b0;
            g0_q <= 1'b0;
            t1_q <= 1'b0;
            t0_q <= 1'b0;
        end else begin
            g1_q <= g1_d;
            g0_q <= g0_d;
            t1_q <= t1_d;
            t0_q <= t0_d;
        end
    end

    // cross-domain term only uses the registered, blinded share
    assign o1 = (a1 & (b1 ^ g0_q)) ^ t1_q;
    assign o0 = (a0 & (b0 ^ g1_q)) ^ t0_q;
endmodule

module skinny_inv_sbox8_dom1_dep_hs (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  si1,
    input  logic [7:0]  si0,
    input  logic [15:0] r,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  bo1,
    output logic [7:0]  bo0,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  y1_q, y1_d, y0_q, y0_d;
    logic [15:0] r_q, r_d;
    logic [7:0]  bo1_q, bo1_d, bo0_q, bo0_d;
    logic        out_valid_q, out_valid_d;

    logic [3:0]  l1_1, l1_0;
    logic [1:0]  l2_1, l2_0;
    logic        l3_1, l3_0, l4_1, l4_0;
    logic [7:0]  x1, x0;

    // layer 1
    skinny_inv_nor_gadget u_k0 (
        .clk(clk), .rst(rst),
        .p1(y1_q[3]), .p0(y0_q[3]),
        .q1(y1_q[1]), .q0(y0_q[1]),
        .z1(y1_q[0]), .z0(y0_q[0]),
        .r(r_q[1:0]),
        .o1(l1_1[0]), .o0(l1_0[0])
    );
    skinny_inv_nor_gadget u_k1 (
        .clk(clk), .rst(rst),
        .p1(y1_q[7]), .p0(y0_q[7]),
        .q1(y1_q[6]), .q0(y0_q[6]),
        .z1(y1_q[4]), .z0(y0_q[4]),
        .r(r_q[3:2]),
        .o1(l1_1[1]), .o0(l1_0[1])
    );
    skinny_inv_nor_gadget u_k2 (
        .clk(clk), .rst(rst),
        .p1(y1_q[2]), .p0(y0_q[2]),
        .q1(y1_q[7]), .q0(y0_q[7]),
        .z1(y1_q[1]), .z0(y0_q[1]),
        .r(r_q[5:4]),
        .o1(l1_1[2]), .o0(l1_0[2])
    );
    skinny_inv_nor_gadget u_k3 (
        .clk(clk), .rst(rst),
        .p1(y1_q[6]), .p0(y0_q[6]),
        .q1(y1_q[5]), .q0(y0_q[5]),
        .z1(y1_q[7]), .z0(y0_q[7]),
        .r(r_q[7:6]),
        .o1(l1_1[3]), .o0(l1_0[3])
    );

    // layer 2
    skinny_inv_nor_gadget u_k4 (
        .clk(clk), .rst(rst),
        .p1(y1_q[5]), .p0(y0_q[5]),
        .q1(l1_1[1]), .q0(l1_0[1]),
        .z1(y1_q[3]), .z0(y0_q[3]),
        .r(r_q[9:8]),
        .o1(l2_1[0]), .o0(l2_0[0])
    );
    skinny_inv_nor_gadget u_k5 (
        .clk(clk), .rst(rst),
        .p1(l1_1[1]), .p0(l1_0[1]),
        .q1(l1_1[0]), .q0(l1_0[0]),
        .z1(y1_q[5]), .z0(y0_q[5]),
        .r(r_q[11:10]),
        .o1(l2_1[1]), .o0(l2_0[1])
    );

    // layers 3 and 4
    skinny_inv_nor_gadget u_k6 (
        .clk(clk), .rst(rst),
        .p1(l1_1[0]), .p0(l1_0[0]),
        .q1(l2_1[0]), .q0(l2_0[0]),
        .z1(y1_q[2]), .z0(y0_q[2]),
        .r(r_q[13:12]),
        .o1(l3_1), .o0(l3_0)
    );
    skinny_inv_nor_gadget u_k7 (
        .clk(clk), .rst(rst),
        .p1(l1_1[2]), .p0(l1_0[2]),
        .q1(l3_1), .q0(l3_0),
        .z1(y1_q[6]), .z0(y0_q[6]),
        .r(r_q[15:14]),
        .o1(l4_1), .o0(l4_0)
    );

    assign x1 = {l1_1[2], l3_1, l1_1[3], l4_1,
                 l1_1[1], l1_1[0], l2_1[0], l2_1[1]};
    assign x0 = {l1_0[2], l3_0, l1_0[3], l4_0,
                 l1_0[1], l1_0[0], l2_0[0], l2_0[1]};

    assign in_ready = (state_q == IDLE) ||
                      ((state_q == DONE) && out_ready);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        y1_d        = y1_q;
        y0_d        = y0_q;
        r_d         = r_q;
        bo1_d       = bo1_q;
        bo0_d       = bo0_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y1_d    = si1;
                    y0_d    = si0;
                    r_d     = r;
                    cnt_d   = 3'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 3'd4) begin
                    bo1_d       = x1;
                    bo0_d       = x0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        y1_d    = si1;
                        y0_d    = si0;
                        r_d     = r;
                        cnt_d   = 3'd0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            y1_q        <= 8'h00;
            y0_q        <= 8'h00;
            r_q         <= 16'h0000;
            bo1_q       <= 8'h00;
            bo0_q       <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y1_q        <= y1_d;
            y0_q        <= y0_d;
            r_q         <= r_d;
            bo1_q       <= bo1_d;
            bo0_q       <= bo0_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bo1       = bo1_q;
    assign bo0       = bo0_q;
    assign out_valid = out_valid_q;
endmodule
